// File: rtl/btn_pkg.sv
// Shared types and timing constants for the push-button pulse generator.
// Holds the repeat FSM state encoding plus board and simulation timing presets.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int DEF_N_BTN    = 4;
  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_DEB_CNT  = 10;
  localparam int DEF_REP_DLY  = 500;
  localparam int DEF_REP_PER  = 100;

  // Short timing so a simulation exercises every path in a few hundred cycles
  localparam int SIM_TICK_DIV = 4;
  localparam int SIM_DEB_CNT  = 3;
  localparam int SIM_REP_DLY  = 8;
  localparam int SIM_REP_PER  = 4;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: tick-sampled debounce followed by the press/repeat/release FSM.
// Pulses are registered in the same edge that updates the debounced level.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_CNT = DEF_DEB_CNT,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic p,
  input  logic en,
  output logic level,
  output logic press,
  output logic rpt,
  output logic rel
);

  localparam int DW = cnt_width(DEB_CNT);
  localparam int RW = cnt_width((REP_DLY > REP_PER) ? REP_DLY : REP_PER);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

  logic          level_reg, level_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic [RW-1:0] rcnt_reg, rcnt_next;
  rep_state_t    state_reg, state_next;
  logic          press_reg, press_next;
  logic          rpt_reg, rpt_next;
  logic          rel_reg, rel_next;
  logic          rise, fall;

  always_comb begin
    level_next = level_reg;
    dcnt_next  = dcnt_reg;
    if (tick) begin
      if (p == level_reg) begin
        dcnt_next = '0;
      end else if (dcnt_reg == DEB_LAST) begin
        level_next = ~level_reg;
        dcnt_next  = '0;
      end else begin
        dcnt_next = dcnt_reg + 1'b1;
      end
    end
  end

  // Edges are taken from the next level so pulses line up with btn_level
  assign rise = level_next & ~level_reg;
  assign fall = ~level_next & level_reg;

  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    press_next = 1'b0;
    rpt_next   = 1'b0;
    rel_next   = 1'b0;
    if (!en) begin
      state_next = IDLE;
      rcnt_next  = '0;
    end else if (fall) begin
      rel_next   = 1'b1;
      state_next = IDLE;
      rcnt_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            press_next = 1'b1;
            rpt_next   = 1'b1;
            rcnt_next  = '0;
            state_next = DELAY;
          end
        end
        DELAY: begin
          if (tick) begin
            if (rcnt_reg == DLY_LAST) begin
              rpt_next   = 1'b1;
              rcnt_next  = '0;
              state_next = REPEAT;
            end else begin
              rcnt_next = rcnt_reg + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (tick) begin
            if (rcnt_reg == PER_LAST) begin
              rpt_next  = 1'b1;
              rcnt_next = '0;
            end else begin
              rcnt_next = rcnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      level_reg <= 1'b0;
      dcnt_reg  <= '0;
      rcnt_reg  <= '0;
      state_reg <= IDLE;
      press_reg <= 1'b0;
      rpt_reg   <= 1'b0;
      rel_reg   <= 1'b0;
    end else begin
      level_reg <= level_next;
      dcnt_reg  <= dcnt_next;
      rcnt_reg  <= rcnt_next;
      state_reg <= state_next;
      press_reg <= press_next;
      rpt_reg   <= rpt_next;
      rel_reg   <= rel_next;
    end
  end

  assign level = level_reg;
  assign press = press_reg;
  assign rpt   = rpt_reg;
  assign rel   = rel_reg;

endmodule

// File: rtl/btn_pulse_gen.sv
// Front-panel button conditioner: synchronises raw active-low buttons and
// shares one sample-tick prescaler across N_BTN debounce/repeat channels.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int N_BTN    = DEF_N_BTN,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DEB_CNT  = DEF_DEB_CNT,
  parameter int REP_DLY  = DEF_REP_DLY,
  parameter int REP_PER  = DEF_REP_PER
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_rpt
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [N_BTN-1:0] sync1_reg, sync2_reg;
  logic [TW-1:0]    pcnt_reg;
  logic             tick;
  logic [N_BTN-1:0] p;

  // Synchroniser resets to "released" so reset never looks like a press
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign p    = ~sync2_reg;
  assign tick = (pcnt_reg == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcnt_reg <= '0;
    end else if (tick) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_channel #(
      .DEB_CNT (DEB_CNT),
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
    ) u_chan (
      .clk   (clk),
      .rstn  (rstn),
      .tick  (tick),
      .p     (p[gi]),
      .en    (en),
      .level (btn_level[gi]),
      .press (btn_press[gi]),
      .rpt   (btn_rpt[gi]),
      .rel   (btn_release[gi])
    );
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen at simulation timing (4/3/8/4).
// Stimulus pushes expected pulse events; a monitor pops them whenever a pulse appears.
module tb_btn_pulse_gen;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic [3:0] btn_n = 4'b1111;
  logic [3:0] btn_level, btn_press, btn_release, btn_rpt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    string      name;
    logic [3:0] press;
    logic [3:0] rpt;
    logic [3:0] rel;
    logic [3:0] level;
    int         gap;
  } ev_t;

  ev_t exp_q[$];

  btn_pulse_gen #(
    .N_BTN    (4),
    .TICK_DIV (SIM_TICK_DIV),
    .DEB_CNT  (SIM_DEB_CNT),
    .REP_DLY  (SIM_REP_DLY),
    .REP_PER  (SIM_REP_PER)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_n       (btn_n),
    .en          (en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_rpt     (btn_rpt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push_ev(input string nm, input logic [3:0] pr, input logic [3:0] rp,
                         input logic [3:0] rl, input logic [3:0] lv, input int gap);
    ev_t e;
    e.name  = nm;
    e.press = pr;
    e.rpt   = rp;
    e.rel   = rl;
    e.level = lv;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // gap != 0 also checks spacing in clk cycles from the previous pulse event
  task automatic monitor();
    int  last_cyc = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      if ((btn_press | btn_rpt | btn_release) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pulse: got press=%b rpt=%b rel=%b at cyc %0d, required none",
                   btn_press, btn_rpt, btn_release, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] cyc=%0d %s press=%b rpt=%b rel=%b level=%b",
                   cyc, e.name, btn_press, btn_rpt, btn_release, btn_level);
          check({e.name, "_press"}, int'(btn_press), int'(e.press));
          check({e.name, "_rpt"}, int'(btn_rpt), int'(e.rpt));
          check({e.name, "_rel"}, int'(btn_release), int'(e.rel));
          check({e.name, "_level"}, int'(btn_level), int'(e.level));
          if (e.gap != 0) check({e.name, "_gap"}, cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  endtask

  task automatic wait_vec(input logic [3:0] want, input int limit, input string nm);
    int n = 0;
    while (btn_level !== want && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(btn_level), int'(want));
  endtask

  initial begin
    logic seen;
    fork
      monitor();
    join_none

    // Reset with every button held
    rstn  = 1'b0;
    en    = 1'b1;
    btn_n = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_level", int'(btn_level), 0);
    check("reset_press", int'(btn_press), 0);
    check("reset_rpt", int'(btn_rpt), 0);
    check("reset_release", int'(btn_release), 0);
    push_ev("all_press", 4'b1111, 4'b1111, 4'b0000, 4'b1111, 0);
    rstn = 1'b1;
    wait_vec(4'b1111, 18, "reset_level_rise");
    push_ev("all_release", 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
    btn_n = 4'b1111;
    wait_vec(4'b0000, 20, "all_release_level");
    repeat (10) @(negedge clk);
    check("queue_after_reset", exp_q.size(), 0);

    // Clean press and release on bit 0
    push_ev("b0_press", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0);
    btn_n = 4'b1110;
    wait_vec(4'b0001, 18, "b0_level_rise");
    push_ev("b0_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0);
    btn_n = 4'b1111;
    wait_vec(4'b0000, 20, "b0_level_fall");
    repeat (10) @(negedge clk);
    check("queue_after_b0", exp_q.size(), 0);

    // Glitch on bit 1: two ticks of disagreement is not enough
    seen  = 1'b0;
    btn_n = 4'b1101;
    repeat (8) begin
      @(negedge clk);
      seen = seen | btn_level[1];
    end
    btn_n = 4'b1111;
    repeat (20) begin
      @(negedge clk);
      seen = seen | btn_level[1];
    end
    check("glitch_level", int'(seen), 0);

    // Auto-repeat on bit 2: press, +32, then every 16 clk
    push_ev("b2_press", 4'b0000 | 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0);
    push_ev("b2_rpt1", 4'b0000, 4'b0100, 4'b0000, 4'b0100, 32);
    for (int k = 2; k <= 5; k++) begin
      push_ev($sformatf("b2_rpt%0d", k), 4'b0000, 4'b0100, 4'b0000, 4'b0100, 16);
    end
    btn_n = 4'b1011;
    wait_vec(4'b0100, 18, "b2_level_rise");
    repeat (97) @(negedge clk);
    check("b2_rpts_seen", exp_q.size(), 0);
    push_ev("b2_release", 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0);
    btn_n = 4'b1111;
    wait_vec(4'b0000, 20, "b2_level_fall");
    repeat (30) @(negedge clk);
    check("queue_after_b2", exp_q.size(), 0);

    // Enable gating on bit 3
    en    = 1'b0;
    btn_n = 4'b0111;
    wait_vec(4'b1000, 18, "b3_gated_level");
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (40) @(negedge clk);
    check("b3_level_held", int'(btn_level), 8);
    push_ev("b3_release_after_gate", 4'b0000, 4'b0000, 4'b1000, 4'b0000, 0);
    btn_n = 4'b1111;
    wait_vec(4'b0000, 20, "b3_level_fall");
    repeat (5) @(negedge clk);
    push_ev("b3_repress", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 0);
    btn_n = 4'b0111;
    wait_vec(4'b1000, 18, "b3_level_rerise");
    push_ev("b3_release", 4'b0000, 4'b0000, 4'b1000, 4'b0000, 0);
    btn_n = 4'b1111;
    wait_vec(4'b0000, 20, "b3_level_refall");
    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
